// File: rtl/tick_pulse_gen_pkg.sv
// ----------------------------------------------------------------------------
// tick_pulse_gen_pkg
// Shared definitions for the tick pulse generator slice:
//   - state_t        : controller state encoding (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH  : default width of the period and divide counter
//                      (26 bits covers a 50 MHz -> 1 Hz divide)
//   - BURST_W        : width of the burst length / ticks remaining count
//   - sat_dec4       : saturating decrement for the 4-bit burst count
// ----------------------------------------------------------------------------
package tick_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 26;
    localparam int BURST_W       = 4;

    // Decrement that sticks at zero instead of wrapping to 4'hF.
    function automatic logic [BURST_W-1:0] sat_dec4(input logic [BURST_W-1:0] value);
        logic [BURST_W-1:0] result;
        if (value == 4'd0) begin
            result = 4'd0;
        end else begin
            result = value - 4'd1;
        end
        return result;
    endfunction

endpackage : tick_pulse_gen_pkg

// File: rtl/tick_pulse_gen_if.sv
// ----------------------------------------------------------------------------
// tick_pulse_gen_if
// Control/status bundle between a controller (master) and the tick
// generator (slave).
//   start      : arm request, honoured only when the generator is idle/done
//   stop       : synchronous abort back to idle, beats start and hold
//   hold       : freezes the divide counter and burst count while running
//   period     : clocks per tick, latched on an accepted start (0 acts as 1)
//   burst_len  : ticks to emit, latched on an accepted start (0 = continuous)
//   tick       : registered single-cycle tick pulse
//   busy       : generator is running
//   done       : burst finished (level, held until re-arm or stop)
//   ticks_left : ticks still to emit in the current burst (0 if continuous)
// ----------------------------------------------------------------------------
interface tick_pulse_gen_if
    import tick_pulse_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic               start;
    logic               stop;
    logic               hold;
    logic [WIDTH-1:0]   period;
    logic [BURST_W-1:0] burst_len;
    logic               tick;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] ticks_left;

    // Controller side: drives the controls, observes the status.
    modport master (
        output start,
        output stop,
        output hold,
        output period,
        output burst_len,
        input  tick,
        input  busy,
        input  done,
        input  ticks_left
    );

    // Generator side: observes the controls, drives the status.
    modport slave (
        input  start,
        input  stop,
        input  hold,
        input  period,
        input  burst_len,
        output tick,
        output busy,
        output done,
        output ticks_left
    );

endinterface : tick_pulse_gen_if

// File: rtl/tick_pulse_gen_reload_down_counter.sv
// ----------------------------------------------------------------------------
// reload_down_counter
// Loadable down counter used as the tick divider.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, clears the count
//   load     : load load_val this edge (takes priority over en)
//   en       : decrement by one this edge; holds at zero, never wraps
//   load_val : value loaded when load is high
//   zero     : count is currently zero
// ----------------------------------------------------------------------------
module reload_down_counter
    import tick_pulse_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register: load wins, otherwise a floor-at-zero decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO_W;
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != ZERO_W)) begin
            count_r <= count_r - ONE_W;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == ZERO_W);

endmodule : reload_down_counter

// File: rtl/tick_pulse_gen.sv
// ----------------------------------------------------------------------------
// tick_pulse_gen
// Divides clk into single-cycle ticks at a run-time period, either as a
// bounded burst (1..15 ticks) or continuously, with hold and abort.
//   clk : rising-edge system clock
//   rst : asynchronous active-high reset; all outputs and counters to 0
//   bus : tick_pulse_gen_if.slave (controls in, tick/busy/done/ticks_left out)
//
// Timing: a start accepted at edge k produces the first tick in the cycle
// after edge k+P and then one every P cycles. The final tick of a burst is
// registered on the same edge that drops busy and raises done.
// ----------------------------------------------------------------------------
module tick_pulse_gen
    import tick_pulse_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    tick_pulse_gen_if.slave   bus
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [WIDTH-1:0]   per_q_r;
    logic [BURST_W-1:0] ticks_left_r;
    logic               tick_r;
    logic               busy_r;
    logic               done_r;

    logic [WIDTH-1:0]   eff_period_s;
    logic               start_ok_s;
    logic               cnt_load_s;
    logic               cnt_en_s;
    logic [WIDTH-1:0]   cnt_load_val_s;
    logic               cnt_zero_s;

    // A zero period would otherwise mean "never tick"; run it as one clock.
    assign eff_period_s = (bus.period == ZERO_W) ? ONE_W : bus.period;

    // Arm is honoured only outside RUN, and never on an abort edge.
    assign start_ok_s = bus.start && !bus.stop && (state_r != ST_RUN);

    // Divider control: abort clears, arm loads the first interval, and in
    // RUN the counter reloads on the edge that emits a tick.
    always_comb begin
        cnt_load_s     = 1'b0;
        cnt_en_s       = 1'b0;
        cnt_load_val_s = ZERO_W;
        if (bus.stop) begin
            cnt_load_s     = 1'b1;
            cnt_load_val_s = ZERO_W;
        end else if (state_r == ST_RUN) begin
            if (bus.hold) begin
                cnt_en_s = 1'b0;
            end else if (cnt_zero_s) begin
                cnt_load_s     = 1'b1;
                cnt_load_val_s = per_q_r - ONE_W;
            end else begin
                cnt_en_s = 1'b1;
            end
        end else if (start_ok_s) begin
            cnt_load_s     = 1'b1;
            cnt_load_val_s = eff_period_s - ONE_W;
        end else begin
            cnt_load_s = 1'b0;
        end
    end

    reload_down_counter #(
        .WIDTH (WIDTH)
    ) u_div_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .en       (cnt_en_s),
        .load_val (cnt_load_val_s),
        .zero     (cnt_zero_s)
    );

    // Controller FSM with burst counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            per_q_r      <= ZERO_W;
            ticks_left_r <= 4'd0;
            tick_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else if (bus.stop) begin
            state_r      <= ST_IDLE;
            ticks_left_r <= 4'd0;
            tick_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    tick_r <= 1'b0;
                    if (start_ok_s) begin
                        state_r      <= ST_RUN;
                        per_q_r      <= eff_period_s;
                        ticks_left_r <= bus.burst_len;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (bus.hold) begin
                        tick_r <= 1'b0;
                    end else if (cnt_zero_s) begin
                        tick_r <= 1'b1;
                        // A nonzero count in RUN means burst mode; zero means
                        // continuous and the count is left alone.
                        if (ticks_left_r != 4'd0) begin
                            ticks_left_r <= sat_dec4(ticks_left_r);
                            if (ticks_left_r == 4'd1) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end else begin
                            ticks_left_r <= 4'd0;
                        end
                    end else begin
                        tick_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    ticks_left_r <= 4'd0;
                    tick_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick       = tick_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.ticks_left = ticks_left_r;

endmodule : tick_pulse_gen

// File: tb/tb_tick_pulse_gen.sv
// ----------------------------------------------------------------------------
// tb_tick_pulse_gen
// Directed scenarios followed by randomized control traffic. A reference
// model tracks the absolute edge number of the next due tick (hold pushes
// it later by one edge per held cycle) and the remaining burst count; the
// DUT outputs are compared against it on every falling edge.
// ----------------------------------------------------------------------------
module tb_tick_pulse_gen;

    localparam int W = 26;

    logic clk = 1'b0;
    logic rst;

    tick_pulse_gen_if #(.WIDTH(W)) bus ();

    tick_pulse_gen #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Reference model state
    bit m_run    = 1'b0;
    bit m_done   = 1'b0;
    bit m_tick   = 1'b0;
    int m_left   = 0;
    int m_period = 1;
    int m_next   = 0;
    int m_edge   = 0;
    int m_start  = 0;
    int m_log[$];
    int exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: advances on each rising edge using the inputs the DUT sees.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_tick = 1'b0;
            m_left = 0;
            m_log.delete();
        end else begin
            m_edge++;
            m_tick = 1'b0;
            if (bus.stop) begin
                m_run  = 1'b0;
                m_done = 1'b0;
                m_left = 0;
            end else if (m_run) begin
                if (bus.hold) begin
                    m_next++;
                end else if (m_edge == m_next) begin
                    m_tick = 1'b1;
                    m_log.push_back(m_edge - m_start);
                    m_next += m_period;
                    if (m_left != 0) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_run  = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                end
            end else if (bus.start) begin
                m_run    = 1'b1;
                m_done   = 1'b0;
                m_period = (bus.period == '0) ? 1 : int'(bus.period);
                m_start  = m_edge;
                m_next   = m_edge + m_period;
                m_left   = int'(bus.burst_len);
                m_log.delete();
            end
        end
    end

    // Compare process: every falling edge, DUT against model.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("tick",       32'(bus.tick),       32'(m_tick));
            chk("busy",       32'(bus.busy),       32'(m_run));
            chk("done",       32'(bus.done),       32'(m_done));
            chk("ticks_left", 32'(bus.ticks_left), 32'(m_left));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Arm: start is sampled on the next rising edge (edge k); returns after it.
    task automatic arm(input int p, input int b);
        bus.period    = W'(p);
        bus.burst_len = 4'(b);
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        step();
    endtask

    // Hand-derived tick offsets form arithmetic sequences: first, step, count.
    task automatic set_exp(input int first, input int stride, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(first + i * stride);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, 32'(m_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < m_log.size(); i++)
            chk(name, 32'(m_log[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.hold      = 1'b0;
        bus.period    = '0;
        bus.burst_len = 4'd0;
        repeat (3) step();
        chk("rst_tick",       32'(bus.tick),       32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_ticks_left", 32'(bus.ticks_left), 32'd0);
        chk_on = 1'b1;
        rst = 1'b0;
        step();

        // Burst of 4 at period 3: ticks at 3,6,9,12, done from 12.
        arm(3, 4);
        repeat (15) step();
        set_exp(3, 3, 4);
        chk_log("s1_ticks");
        chk("s1_done", 32'(bus.done), 32'd1);
        chk("s1_left", 32'(bus.ticks_left), 32'd0);
        do_stop();

        // Period 0 behaves as 1: ticks at 1,2.
        arm(0, 2);
        repeat (4) step();
        set_exp(1, 1, 2);
        chk_log("s2_ticks");
        chk("s2_done", 32'(bus.done), 32'd1);

        // Continuous at period 5 (re-armed from DONE), stop sampled at edge 23.
        arm(5, 0);
        repeat (22) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        repeat (20) step();
        set_exp(5, 5, 4);
        chk_log("s3_ticks");
        chk("s3_busy", 32'(bus.busy), 32'd0);

        // Period 4, burst 3, hold sampled on edges 2..4: ticks at 7,11,15.
        // A start (with new settings) at edge 9 must be ignored.
        arm(4, 3);
        step();
        bus.hold = 1'b1;
        repeat (3) step();
        bus.hold = 1'b0;
        repeat (4) step();
        bus.start     = 1'b1;
        bus.period    = W'(1);
        bus.burst_len = 4'd9;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        set_exp(7, 4, 3);
        chk_log("s4_ticks");
        chk("s4_done", 32'(bus.done), 32'd1);

        // Start and stop together: stop wins, from DONE and from IDLE.
        for (int r = 0; r < 2; r++) begin
            bus.start = 1'b1;
            bus.stop  = 1'b1;
            step();
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            step();
            chk("s5_busy", 32'(bus.busy), 32'd0);
            chk("s5_done", 32'(bus.done), 32'd0);
        end

        // Asynchronous reset mid-burst, then a fresh burst of 8 at period 2.
        arm(2, 8);
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        chk("s6_tick",       32'(bus.tick),       32'd0);
        chk("s6_busy",       32'(bus.busy),       32'd0);
        chk("s6_ticks_left", 32'(bus.ticks_left), 32'd0);
        step();
        rst = 1'b0;
        step();
        arm(2, 8);
        repeat (18) step();
        set_exp(2, 2, 8);
        chk_log("s6_ticks");
        chk("s6_done", 32'(bus.done), 32'd1);

        // Randomized control traffic, including occasional async resets.
        for (int i = 0; i < 1500; i++) begin
            bus.start     = ($urandom_range(0, 5) == 0);
            bus.stop      = ($urandom_range(0, 49) == 0);
            bus.hold      = ($urandom_range(0, 4) == 0);
            bus.period    = W'($urandom_range(0, 7));
            bus.burst_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.hold  = 1'b0;
        step();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_tick_pulse_gen
